weight_load_seq: RTL and testbench

//   Sequencer that streams weights from the weight RAM into the neuron units.
//   On start it issues NUM_UNITS*WEIGHTS_PER_UNIT sequential RAM reads and presents each word on
//   ram_out with the matching unit_sel and a one-cycle write strobe.

---
 rtl/weight_load_seq_if.sv | 28 ++
 rtl/weight_load_seq.sv | 116 +++++++++++
 tb/tb_weight_load_seq.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/weight_load_seq_if.sv
// Bus between the weight-load sequencer, the weight RAM and the per-unit demux.
// The slave side is the sequencer; the master side is the controller/RAM/demux environment.
interface weight_load_seq_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              hold;
  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic [DATA_W-1:0] ram_out;
  logic [2:0]        unit_sel;
  logic              write;
  logic              busy;
  logic              done;

  modport master (
    output start, base_addr, hold, ram_data,
    input  ram_en, ram_addr, ram_out, unit_sel, write, busy, done
  );

  modport slave (
    input  start, base_addr, hold, ram_data,
    output ram_en, ram_addr, ram_out, unit_sel, write, busy, done
  );
endinterface

// File: rtl/weight_load_seq.sv
// Streams NUM_UNITS*WEIGHTS_PER_UNIT sequential RAM words to the unit demux; write lags its read by 2 cycles.
// hold stalls only the issue of new reads; reads already in flight always complete.
module weight_load_seq #(
  parameter int NUM_UNITS        = 4,
  parameter int WEIGHTS_PER_UNIT = 16,
  parameter int ADDR_W           = 8,
  parameter int DATA_W           = 32
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  weight_load_seq_if.slave bus
);
  localparam int TOTAL  = NUM_UNITS * WEIGHTS_PER_UNIT;
  localparam int CNT_W  = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int WIDX_W = (WEIGHTS_PER_UNIT > 1) ? $clog2(WEIGHTS_PER_UNIT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_unit;
  logic [WIDX_W-1:0] r_widx;
  logic              r_p1_vld;
  logic [2:0]        r_p1_tag;
  logic [DATA_W-1:0] r_ram_out;
  logic [2:0]        r_unit_sel;
  logic              r_write;
  logic              r_busy;
  logic              r_done;

  logic w_issue;
  logic w_last;
  logic w_unit_end;

  // Read enable must respond to hold in the same cycle, so it is decoded from the state register.
  assign w_issue    = (r_state == S_ISSUE) && !bus.hold;
  assign w_last     = (r_cnt == CNT_W'(TOTAL - 1));
  assign w_unit_end = (r_widx == WIDX_W'(WEIGHTS_PER_UNIT - 1));

  assign bus.ram_en   = w_issue;
  assign bus.ram_addr = w_issue ? (r_base + ADDR_W'(r_cnt)) : '0;
  assign bus.ram_out  = r_ram_out;
  assign bus.unit_sel = r_unit_sel;
  assign bus.write    = r_write;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_cnt      <= '0;
      r_unit     <= '0;
      r_widx     <= '0;
      r_p1_vld   <= 1'b0;
      r_p1_tag   <= '0;
      r_ram_out  <= '0;
      r_unit_sel <= '0;
      r_write    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_p1_vld <= w_issue;
      r_write  <= r_p1_vld;
      if (w_issue) begin
        r_p1_tag <= r_unit;
      end
      // Data and tag are only refreshed on a real write so they hold between strobes.
      if (r_p1_vld) begin
        r_ram_out  <= bus.ram_data;
        r_unit_sel <= r_p1_tag;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_ISSUE;
            r_base  <= bus.base_addr;
            r_cnt   <= '0;
            r_unit  <= '0;
            r_widx  <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (w_issue) begin
            if (w_last) begin
              r_state <= S_DRAIN;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_unit_end) begin
              r_widx <= '0;
              r_unit <= r_unit + 3'd1;
            end else begin
              r_widx <= r_widx + WIDX_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (!r_p1_vld) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_weight_load_seq.sv
// Bench for weight_load_seq: directed vector table, reset corner cases and random loads vs a cycle-level reference.
module tb_weight_load_seq;
  localparam int NU   = 4;
  localparam int WPU  = 16;
  localparam int N    = NU * WPU;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int HMAX = 320;

  typedef struct {int t; logic [2:0] u; logic [DW-1:0] d;} wr_t;
  typedef struct {int t; logic [AW-1:0] a;} rd_t;
  typedef struct {
    logic [7:0]  base;
    int          hold_at;
    int          hold_len;
    bit          start_mid;
    int          exp_done;
    logic [31:0] exp_first;
    logic [31:0] exp_w15;
    logic [31:0] exp_last;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  weight_load_seq_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();

  weight_load_seq #(
    .NUM_UNITS(NU), .WEIGHTS_PER_UNIT(WPU), .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .CLOCK(clk),
    .RESET_N(rst_n),
    .bus(ifc)
  );

  logic [DW-1:0] mem [256];
  bit   hold_pat [HMAX];
  bit   start_pat[HMAX];
  wr_t  wq[$], ew[$];
  rd_t  rq[$], er[$];
  int   dq[$];
  bit   bq[$];
  int   exp_done;
  int   cyc = 0;
  int   t0 = 0;
  bit   log_on = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM: one-cycle read latency; garbage when not enabled
  always @(posedge clk) ifc.ram_data <= ifc.ram_en ? mem[ifc.ram_addr] : DW'($urandom);

  always @(negedge clk) begin
    if (log_on) begin
      if (ifc.write)  wq.push_back('{cyc - t0, ifc.unit_sel, ifc.ram_out});
      if (ifc.ram_en) rq.push_back('{cyc - t0, ifc.ram_addr});
      if (ifc.done)   dq.push_back(cyc - t0);
      bq.push_back(ifc.busy);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({ifc.ram_en, ifc.ram_addr, ifc.ram_out, ifc.unit_sel, ifc.write, ifc.busy, ifc.done});
  endfunction

  // Reference: read i goes out in the i-th cycle (from cycle 1) where hold is low,
  // its write appears 2 cycles later, done 3 cycles after the final read.
  task automatic model(input logic [7:0] base);
    int t;
    logic [7:0] a;
    t = 1;
    ew.delete();
    er.delete();
    for (int i = 0; i < N; i++) begin
      while (t < HMAX - 8 && hold_pat[t]) t++;
      a = base + 8'(i);
      er.push_back('{t, a});
      ew.push_back('{t + 2, 3'(i / WPU), mem[a]});
      t++;
    end
    exp_done = er[N-1].t + 3;
  endtask

  task automatic clear_pats();
    for (int c = 0; c < HMAX; c++) begin
      hold_pat[c]  = 1'b0;
      start_pat[c] = 1'b0;
    end
  endtask

  task automatic do_load(input logic [7:0] base, input bit start_in_done);
    model(base);
    if (start_in_done) start_pat[exp_done] = 1'b1;
    wq.delete(); rq.delete(); dq.delete(); bq.delete();
    @(posedge clk); #1;
    t0 = cyc;
    log_on = 1'b1;
    ifc.start = 1'b1;
    ifc.base_addr = base;
    ifc.hold = hold_pat[0];
    for (int c = 1; c <= exp_done + 6; c++) begin
      @(posedge clk); #1;
      ifc.start = start_pat[c];
      ifc.hold = hold_pat[c];
      ifc.base_addr = AW'($urandom);
    end
    @(posedge clk); #1;
    log_on = 1'b0;
    ifc.start = 1'b0;
    ifc.hold = 1'b0;
  endtask

  task automatic check_load(input string tag);
    int berr;
    berr = 0;
    chk({tag, ".n_writes"}, 64'(wq.size()), 64'(N));
    chk({tag, ".n_reads"}, 64'(rq.size()), 64'(N));
    for (int i = 0; i < N && i < wq.size(); i++)
      chk($sformatf("%s.write%0d{cyc,unit,data}", tag, i),
          {16'(wq[i].t), 5'd0, wq[i].u, wq[i].d}, {16'(ew[i].t), 5'd0, ew[i].u, ew[i].d});
    for (int i = 0; i < N && i < rq.size(); i++)
      chk($sformatf("%s.read%0d{cyc,addr}", tag, i), {16'(rq[i].t), rq[i].a}, {16'(er[i].t), er[i].a});
    chk({tag, ".n_done"}, 64'(dq.size()), 64'd1);
    chk({tag, ".done_cycle"}, 64'(dq.size() > 0 ? dq[0] : -1), 64'(exp_done));
    for (int r = 0; r < bq.size(); r++)
      if (bq[r] !== (r >= 1 && r <= exp_done)) berr++;
    chk({tag, ".busy_window_errors"}, 64'(berr), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[4];
    logic [7:0] a33;
    vt[0] = '{8'h10, 0,  0, 1'b0, 67, 32'h10, 32'h1F, 32'h4F};
    vt[1] = '{8'hF8, 0,  0, 1'b0, 67, 32'hF8, 32'h07, 32'h37};
    vt[2] = '{8'h10, 11, 5, 1'b0, 72, 32'h10, 32'h1F, 32'h4F};
    vt[3] = '{8'h10, 0,  0, 1'b1, 67, 32'h10, 32'h1F, 32'h4F};

    ifc.start = 1'b0; ifc.base_addr = '0; ifc.hold = 1'b0;
    clear_pats();

    // Reset held with random inputs: every output must stay zero
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      ifc.start = 1'($urandom); ifc.base_addr = AW'($urandom); ifc.hold = 1'($urandom);
      @(negedge clk);
      chk("reset_outputs", outs(), 64'd0);
    end
    @(posedge clk); #1;
    ifc.start = 1'b0; ifc.hold = 1'b0;
    #2 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("idle_after_reset{ram_en,busy,write}", {ifc.ram_en, ifc.busy, ifc.write}, 3'b000);
    end

    // Directed table: plain, address wrap, hold gap, stray starts mid-load and in DONE
    for (int v = 0; v < 4; v++) begin
      clear_pats();
      for (int a = 0; a < 256; a++) mem[a] = DW'(a);
      for (int k = 0; k < vt[v].hold_len; k++) hold_pat[vt[v].hold_at + k] = 1'b1;
      if (vt[v].start_mid) start_pat[20] = 1'b1;
      do_load(vt[v].base, vt[v].start_mid);
      check_load($sformatf("vec%0d", v));
      chk($sformatf("vec%0d.table_done", v), 64'(dq.size() > 0 ? dq[0] : -1), 64'(vt[v].exp_done));
      chk($sformatf("vec%0d.first_data", v), 64'(wq.size() > 0 ? wq[0].d : 32'hDEADBEEF), 64'(vt[v].exp_first));
      chk($sformatf("vec%0d.write15_data", v), 64'(wq.size() > 15 ? wq[15].d : 32'hDEADBEEF), 64'(vt[v].exp_w15));
      chk($sformatf("vec%0d.last_data", v), 64'(wq.size() > 0 ? wq[wq.size()-1].d : 32'hDEADBEEF), 64'(vt[v].exp_last));
      chk($sformatf("vec%0d.last_unit", v), 64'(wq.size() > 0 ? wq[wq.size()-1].u : 3'd7), 64'd3);
    end

    // Asynchronous reset at the 20th write, then a clean restart
    clear_pats();
    for (int a = 0; a < 256; a++) mem[a] = $urandom;
    @(posedge clk); #1;
    ifc.start = 1'b1; ifc.base_addr = 8'h20; ifc.hold = 1'b0;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    repeat (21) @(posedge clk);
    #1;
    a33 = 8'h20 + 8'd19;
    chk("write20_before_reset{write,unit,data}", {ifc.write, 3'b0, ifc.unit_sel, ifc.ram_out},
        {1'b1, 3'b0, 3'd1, mem[a33]});
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", outs(), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("no_activity_after_reset{ram_en,write,busy}", {ifc.ram_en, ifc.write, ifc.busy}, 3'b000);
    end
    do_load(8'h20, 1'b0);
    check_load("restart");

    // Random loads: random RAM, base, hold pattern and stray starts
    for (int it = 0; it < 5; it++) begin
      clear_pats();
      for (int a = 0; a < 256; a++) mem[a] = $urandom;
      for (int c = 0; c <= 150; c++) hold_pat[c] = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < 3; k++) start_pat[$urandom_range(1, 60)] = 1'b1;
      do_load(8'($urandom), 1'($urandom_range(0, 1)));
      check_load($sformatf("rand%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
